mtimer_responder: RTL and testbench
===================================

Name: mtimer_responder

Overview:
Memory-mapped machine timer that answers the CPU core's data-memory port: address, store data, write enable and funct3 in; load data out.
- Holds a 64-bit mtime counter with a prescaler and a 64-bit mtimecmp, and drives the core's int_req line.
- Performs all byte, halfword and word lane steering and load sign/zero extension, because the core writes dmem_r_data straight into the register file.
- Sits beside data RAM on the dmem bus; the top level muxes read data using the sel output.

Parameters:
BASE_ADDR, 32'hFFFF0000, word-aligned base of the register window
DIV_DEFAULT, 8'd0, reset value of PRESCALE (mtime ticks every DIV+1 clocks)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
dmem_rw_addr  input  32  byte address from core
dmem_w_data  input  32  store data (core rs2_data, unshifted)
dmem_w_en  input  1  store strobe, sampled at posedge clock
funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
dmem_r_data  output  32  combinational load data, extended
sel  output  1  address hits the window (combinational)
int_req  output  1  registered timer interrupt request

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL (bit0 cnt_en, bit1 irq_en; other bits read 0)
  - 0x14 PRESCALE (bits 7:0; others read 0)
- sel=1 iff BASE_ADDR <= addr < BASE_ADDR+0x18. With the optional feature the window is +0x1C.
- Read (combinational):
  - Select word by addr[4:2] and shift right by 8*addr[1:0].
  - 000: sign-extend byte. 100: zero-extend byte.
  - 001: sign-extend half. 101: zero-extend half.
  - 010: full word.
  - Misaligned half (addr[0]=1), misaligned word (addr[1:0]!=0), other funct3, or sel=0: dmem_r_data=0.
- Write (posedge, dmem_w_en & sel):
  - 000 writes byte lane addr[1:0] from dmem_w_data[7:0].
  - 001 writes half lane addr[1] from [15:0].
  - 010 writes whole word.
  - Misaligned or other funct3: no state change.
- Prescaler: 8-bit pcnt, active only when cnt_en=1.
  - pcnt==PRESCALE: pcnt<=0 and mtime<=mtime+1 (full 64-bit carry, wraps FFFF_FFFF_FFFF_FFFF -> 0).
  - Otherwise: pcnt<=pcnt+1.
  - cnt_en=0: pcnt and mtime hold.
- Simultaneous events:
  - A write to MTIME_LO or MTIME_HI suppresses that cycle's increment. The written half takes the new value; the other half holds.
  - A write to CTRL or PRESCALE clears pcnt to 0.
- int_req <= irq_en & (mtime >= mtimecmp), unsigned 64-bit compare on current register values. This gives one cycle of latency after the condition first holds.
  - Raising mtimecmp above mtime drops int_req on the following posedge.
  - Clearing irq_en drops int_req on the following posedge.
- Reset (synchronous, overrides all writes in that cycle):
  - mtime=0, mtimecmp=64'hFFFFFFFF_FFFFFFFF
  - CTRL=0, PRESCALE=DIV_DEFAULT, pcnt=0, int_req=0
  - With the optional feature, PERIOD=0.
- Reset mid-count simply restarts from 0. dmem_r_data and sel are combinational and are not affected by reset except through register contents.

Optional Feature:
MTIMER_PERIODIC_EN
- Defined:
  - Adds 0x18 PERIOD (32-bit, zero-extended to 64) and CTRL bit2 periodic.
  - When periodic=1 and mtime>=mtimecmp, mtimecmp <= mtimecmp+PERIOD, then the compare re-evaluates.
  - A software write to MTIMECMP in the same cycle wins over the auto-advance.
- Undefined:
  - Window ends at 0x18, so offset 0x18 has sel=0.
  - CTRL bit2 is not stored and reads 0.
  - mtimecmp changes only by software write.

Test Plan:
- Reset, then lw at BASE+0x08 and BASE+0x0C -> 0xFFFFFFFF each; lw at BASE+0x10 -> 0; int_req=0.
- sw 0x00000003 to PRESCALE, sw 0x1 to CTRL, run 40 clocks -> MTIME_LO reads 10.
- sb 0x80 to BASE+0x0A (cmp byte2), then lb and lbu at BASE+0x0A -> 0xFFFFFF80 and 0x00000080; lh at BASE+0x09 (misaligned) -> 0, no state change.
- sw 0xFFFFFFFF to MTIME_LO, sw 0 to MTIME_HI, cnt_en=1, PRESCALE=0 -> after one tick MTIME_LO=0, MTIME_HI=1.
- mtimecmp=5 (HI=0), CTRL=0x3, PRESCALE=0, mtime=0 -> int_req rises exactly one clock after mtime reaches 5; writing MTIMECMP_LO=100 drops it the next cycle.
- With MTIMER_PERIODIC_EN: PERIOD=10, cmp=5, CTRL=0x7 -> mtimecmp reads 15, 25, 35 as mtime crosses each value; reset mid-run -> all registers at reset values.

Source files
------------

// File: rtl/mtimer_responder.sv
// Memory-mapped machine timer on the dmem bus; MTIMER_PERIODIC_EN adds PERIOD auto-reload.
// Loads are combinational, stores take effect at the next clock edge, int_req is registered; never stalls the core.
module mtimer_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
    parameter logic [7:0]  DIV_DEFAULT = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dmem_rw_addr,
    input  logic [31:0] dmem_w_data,
    input  logic        dmem_w_en,
    input  logic [2:0]  funct3,
    output logic [31:0] dmem_r_data,
    output logic        sel,
    output logic        int_req
);

`ifdef MTIMER_PERIODIC_EN
    localparam logic [31:0] WIN = 32'h1C;
    localparam int          CW  = 3;
`else
    localparam logic [31:0] WIN = 32'h18;
    localparam int          CW  = 2;
`endif

    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [CW-1:0] ctrl_q, ctrl_d;
    logic [7:0]    prescale_q, prescale_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic          int_req_q, int_req_d;
`ifdef MTIMER_PERIODIC_EN
    logic [31:0]   period_q, period_d;
`endif

    logic [31:0] off;
    logic [2:0]  idx;
    logic [1:0]  lane;
    logic [31:0] rword, shifted, wlane, bitmask, wnew;
    logic [3:0]  bmask;
    logic [7:0]  wr_sel;
    logic        cmp_hit;

    // Unsigned offset compare also rejects addresses below the base (they wrap high).
    assign off     = dmem_rw_addr - BASE_ADDR;
    assign sel     = off < WIN;
    assign idx     = off[4:2];
    assign lane    = off[1:0];
    assign cmp_hit = mtime_q >= mtimecmp_q;
    assign int_req = int_req_q;

    always_comb begin
        rword = '0;
        case (idx)
            3'd0:    rword = mtime_q[31:0];
            3'd1:    rword = mtime_q[63:32];
            3'd2:    rword = mtimecmp_q[31:0];
            3'd3:    rword = mtimecmp_q[63:32];
            3'd4:    rword = {{(32-CW){1'b0}}, ctrl_q};
            3'd5:    rword = {24'd0, prescale_q};
`ifdef MTIMER_PERIODIC_EN
            3'd6:    rword = period_q;
`endif
            default: rword = '0;
        endcase
    end

    assign shifted = rword >> {lane, 3'b000};

    always_comb begin
        dmem_r_data = '0;
        case (funct3)
            3'b000: dmem_r_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100: dmem_r_data = {24'd0, shifted[7:0]};
            3'b001: if (!lane[0]) dmem_r_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101: if (!lane[0]) dmem_r_data = {16'd0, shifted[15:0]};
            3'b010: if (lane == 2'b00) dmem_r_data = shifted;
            default: dmem_r_data = '0;
        endcase
        if (!sel) dmem_r_data = '0;
    end

    // Byte-enable mask; an empty mask means misaligned, unsupported or not for us.
    always_comb begin
        bmask = 4'b0000;
        wlane = '0;
        case (funct3)
            3'b000: begin
                bmask = 4'b0001 << lane;
                wlane = {4{dmem_w_data[7:0]}};
            end
            3'b001: begin
                if (!lane[0]) bmask = lane[1] ? 4'b1100 : 4'b0011;
                wlane = {2{dmem_w_data[15:0]}};
            end
            3'b010: begin
                if (lane == 2'b00) bmask = 4'b1111;
                wlane = dmem_w_data;
            end
            default: begin
                bmask = 4'b0000;
                wlane = '0;
            end
        endcase
        if (!(dmem_w_en && sel)) bmask = 4'b0000;
    end

    assign bitmask = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
    assign wnew    = (rword & ~bitmask) | (wlane & bitmask);
    assign wr_sel  = (|bmask) ? (8'd1 << idx) : 8'd0;

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
`ifdef MTIMER_PERIODIC_EN
        period_d   = period_q;
`endif
        int_req_d  = ctrl_q[1] & cmp_hit;

        if (ctrl_q[0]) begin
            if (pcnt_q == prescale_q) begin
                pcnt_d  = 8'd0;
                mtime_d = mtime_q + 64'd1;
            end else begin
                pcnt_d  = pcnt_q + 8'd1;
            end
        end

        // A store to either mtime half replaces this cycle's increment entirely.
        if (wr_sel[0]) mtime_d = {mtime_q[63:32], wnew};
        if (wr_sel[1]) mtime_d = {wnew, mtime_q[31:0]};

`ifdef MTIMER_PERIODIC_EN
        if (ctrl_q[2] && cmp_hit) mtimecmp_d = mtimecmp_q + {32'd0, period_q};
        if (wr_sel[6]) period_d = wnew;
`endif
        if (wr_sel[2]) mtimecmp_d = {mtimecmp_q[63:32], wnew};
        if (wr_sel[3]) mtimecmp_d = {wnew, mtimecmp_q[31:0]};

        if (wr_sel[4]) begin
            ctrl_d = wnew[CW-1:0];
            pcnt_d = 8'd0;
        end
        if (wr_sel[5]) begin
            prescale_d = wnew[7:0];
            pcnt_d     = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            ctrl_q     <= '0;
            prescale_q <= DIV_DEFAULT;
            pcnt_q     <= '0;
            int_req_q  <= 1'b0;
`ifdef MTIMER_PERIODIC_EN
            period_q   <= '0;
`endif
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            int_req_q  <= int_req_d;
`ifdef MTIMER_PERIODIC_EN
            period_q   <= period_d;
`endif
        end
    end

endmodule

// File: tb/tb_mtimer_responder.sv
// Directed bench for mtimer_responder: register access, prescaled counting, carry, interrupt timing, reset.
module tb_mtimer_responder;

    localparam logic [31:0] B   = 32'hFFFF0000;
    localparam logic [2:0]  F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic        clock;
    logic        reset;
    logic [31:0] dmem_rw_addr;
    logic [31:0] dmem_w_data;
    logic        dmem_w_en;
    logic [2:0]  funct3;
    logic [31:0] dmem_r_data;
    logic        sel;
    logic        int_req;

    int checks = 0;
    int errors = 0;

    mtimer_responder #(.BASE_ADDR(B), .DIV_DEFAULT(8'd0)) dut (
        .clock        (clock),
        .reset        (reset),
        .dmem_rw_addr (dmem_rw_addr),
        .dmem_w_data  (dmem_w_data),
        .dmem_w_en    (dmem_w_en),
        .funct3       (funct3),
        .dmem_r_data  (dmem_r_data),
        .sel          (sel),
        .int_req      (int_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        dmem_rw_addr = a;
        dmem_w_data  = d;
        funct3       = f;
        dmem_w_en    = 1'b1;
        @(posedge clock);
        #1;
        dmem_w_en    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] f, input logic [31:0] exp, input string tag);
        dmem_rw_addr = a;
        funct3       = f;
        dmem_w_en    = 1'b0;
        #1;
        chk(tag, dmem_r_data, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        dmem_rw_addr = '0;
        dmem_w_data  = '0;
        dmem_w_en    = 1'b0;
        funct3       = F_W;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state and window decode
        chk("rst_int", int_req, 0);
        rd(B + 32'h08, F_W, 32'hFFFFFFFF, "rst_cmp_lo");
        rd(B + 32'h0C, F_W, 32'hFFFFFFFF, "rst_cmp_hi");
        rd(B + 32'h10, F_W, 32'h0, "rst_ctrl");
        rd(B + 32'h14, F_W, 32'h0, "rst_prescale");
        rd(B + 32'h00, F_W, 32'h0, "rst_mtime_lo");
        dmem_rw_addr = B + 32'h14; #1;
        chk("sel_last", sel, 1);
        dmem_rw_addr = B - 32'h4; #1;
        chk("sel_below", sel, 0);
        dmem_rw_addr = B + 32'h18; #1;
`ifdef MTIMER_PERIODIC_EN
        chk("sel_0x18", sel, 1);
`else
        chk("sel_0x18", sel, 0);
        rd(B + 32'h18, F_W, 32'h0, "rd_0x18");
`endif

        // Prescale 3: one tick per 4 clocks, 40 clocks -> 10
        wr(B + 32'h14, 32'h3, F_W);
        wr(B + 32'h10, 32'h1, F_W);
        repeat (40) @(posedge clock);
        #1;
        rd(B + 32'h00, F_W, 32'd10, "presc_lo");
        wr(B + 32'h10, 32'h0, F_W);
        rd(B + 32'h00, F_W, 32'd10, "stopped_lo");
        rd(B + 32'h04, F_W, 32'd0, "stopped_hi");

        // Lane steering and extension
        wr(B + 32'h0A, 32'h00000080, F_B);
        rd(B + 32'h0A, F_B,  32'hFFFFFF80, "lb");
        rd(B + 32'h0A, F_BU, 32'h00000080, "lbu");
        rd(B + 32'h08, F_W,  32'hFF80FFFF, "lw_after_sb");
        rd(B + 32'h09, F_H,  32'h0, "lh_misaligned");
        wr(B + 32'h09, 32'h00001234, F_H);
        rd(B + 32'h08, F_W,  32'hFF80FFFF, "sh_misaligned_nochg");
        rd(B + 32'h0A, F_H,  32'hFFFFFF80, "lh_upper");
        rd(B + 32'h0A, F_HU, 32'h0000FF80, "lhu_upper");
        rd(B + 32'h0A, F_W,  32'h0, "lw_misaligned");
        rd(B + 32'h08, 3'b011, 32'h0, "bad_funct3");
        wr(B + 32'h0C, 32'h0000ABCD, F_H);
        rd(B + 32'h0C, F_W,  32'hFFFFABCD, "sh_lane0");
        rd(B + 32'h0C, F_H,  32'hFFFFABCD, "lh_lane0");
        rd(B + 32'h0F, F_BU, 32'h000000FF, "lbu_lane3");

        // 32-bit carry into the high word
        wr(B + 32'h00, 32'hFFFFFFFF, F_W);
        wr(B + 32'h04, 32'h0, F_W);
        wr(B + 32'h14, 32'h0, F_W);
        wr(B + 32'h10, 32'h1, F_W);
        step();
        rd(B + 32'h00, F_W, 32'h0, "carry_lo");
        rd(B + 32'h04, F_W, 32'h1, "carry_hi");
        // Store to MTIME_LO wins over the increment; high half holds
        wr(B + 32'h00, 32'h50, F_W);
        rd(B + 32'h00, F_W, 32'h50, "wr_sup_lo");
        rd(B + 32'h04, F_W, 32'h1, "wr_sup_hi");
        wr(B + 32'h10, 32'h0, F_W);
        rd(B + 32'h00, F_W, 32'h51, "resume_lo");

        // Full 64-bit wrap
        wr(B + 32'h00, 32'hFFFFFFFF, F_W);
        wr(B + 32'h04, 32'hFFFFFFFF, F_W);
        wr(B + 32'h10, 32'h1, F_W);
        step();
        rd(B + 32'h00, F_W, 32'h0, "wrap_lo");
        rd(B + 32'h04, F_W, 32'h0, "wrap_hi");
        wr(B + 32'h10, 32'h0, F_W);

        // Interrupt timing
        wr(B + 32'h00, 32'h0, F_W);
        wr(B + 32'h04, 32'h0, F_W);
        wr(B + 32'h0C, 32'h0, F_W);
        wr(B + 32'h08, 32'h5, F_W);
        wr(B + 32'h10, 32'h3, F_W);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("irq_before", int_req, 0);
        end
        rd(B + 32'h00, F_W, 32'h5, "irq_mtime5");
        step();
        chk("irq_rise", int_req, 1);
        wr(B + 32'h08, 32'd100, F_W);
        chk("irq_hold_after_cmpwr", int_req, 1);
        step();
        chk("irq_drop_cmp", int_req, 0);
        wr(B + 32'h08, 32'd0, F_W);
        chk("irq_lat_cmp0", int_req, 0);
        step();
        chk("irq_cmp0", int_req, 1);
        wr(B + 32'h10, 32'h1, F_W);
        chk("irq_hold_after_en", int_req, 1);
        step();
        chk("irq_drop_en", int_req, 0);

        // Reset mid-count overrides a simultaneous store
        dmem_rw_addr = B + 32'h10;
        dmem_w_data  = 32'h3;
        funct3       = F_W;
        dmem_w_en    = 1'b1;
        reset        = 1'b1;
        step();
        reset     = 1'b0;
        dmem_w_en = 1'b0;
        chk("rst2_int", int_req, 0);
        rd(B + 32'h10, F_W, 32'h0, "rst2_ctrl");
        rd(B + 32'h00, F_W, 32'h0, "rst2_lo");
        rd(B + 32'h08, F_W, 32'hFFFFFFFF, "rst2_cmp_lo");
        step();
        rd(B + 32'h00, F_W, 32'h0, "rst2_hold");

`ifdef MTIMER_PERIODIC_EN
        // Periodic auto-advance of mtimecmp
        wr(B + 32'h18, 32'd10, F_W);
        wr(B + 32'h0C, 32'h0, F_W);
        wr(B + 32'h08, 32'h5, F_W);
        rd(B + 32'h18, F_W, 32'd10, "period_rd");
        wr(B + 32'h10, 32'h7, F_W);
        rd(B + 32'h10, F_W, 32'h7, "ctrl_periodic");
        repeat (5) step();
        rd(B + 32'h08, F_W, 32'd5, "per_cmp5");
        step();
        chk("per_irq", int_req, 1);
        rd(B + 32'h08, F_W, 32'd15, "per_cmp15");
        step();
        chk("per_irq_drop", int_req, 0);
        repeat (8) step();
        rd(B + 32'h00, F_W, 32'd15, "per_mtime15");
        rd(B + 32'h08, F_W, 32'd15, "per_cmp15_hold");
        step();
        rd(B + 32'h08, F_W, 32'd25, "per_cmp25");
        repeat (10) step();
        rd(B + 32'h08, F_W, 32'd35, "per_cmp35");
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(B + 32'h08, F_W, 32'hFFFFFFFF, "per_rst_cmp");
        rd(B + 32'h18, F_W, 32'h0, "per_rst_period");
        rd(B + 32'h10, F_W, 32'h0, "per_rst_ctrl");
        rd(B + 32'h00, F_W, 32'h0, "per_rst_mtime");
`else
        // CTRL bit2 is not stored without the periodic feature
        wr(B + 32'h10, 32'h4, F_W);
        rd(B + 32'h10, F_W, 32'h0, "ctrl_bit2_absent");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
